// File: rtl/thermostat_pkg.sv
// ============================================================================
// thermostat_pkg : shared setpoint type, default limits and repeat-FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package thermostat_pkg;

   typedef logic [7:0] temp_t;

   localparam temp_t TEMP_MIN_DEF  = 8'd50;
   localparam temp_t TEMP_MAX_DEF  = 8'd90;
   localparam temp_t TEMP_INIT_DEF = 8'd72;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      HOLD_DELAY = 2'd1,
      REPEAT     = 2'd2
   } rep_state_t;

   // One clamped 1 degree step; the value never leaves [lo, hi].
   function automatic temp_t step_temp(input temp_t cur, input logic up,
                                       input temp_t lo, input temp_t hi);
      temp_t res;
      res = cur;
      if (up) begin
         if (cur < hi) res = cur + 8'd1;
      end else begin
         if (cur > lo) res = cur - 8'd1;
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce : 2-flop synchronizer plus stable-count debouncer for one button
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // The count only advances while the synchronized input disagrees with the
   // accepted level; any agreement (a bounce back) restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/setpoint_entry.sv
// ============================================================================
// setpoint_entry : debounced up/down/default buttons stepping a clamped setpoint
// Optional auto-repeat while held: define SETPOINT_AUTOREPEAT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module setpoint_entry
   import thermostat_pkg::*;
#(
   parameter int    DEBOUNCE_CYCLES = 1_000_000,
   parameter int    REPEAT_DELAY    = 50_000_000,
   parameter int    REPEAT_PERIOD   = 20_000_000,
   parameter temp_t TEMP_MIN        = TEMP_MIN_DEF,
   parameter temp_t TEMP_MAX        = TEMP_MAX_DEF,
   parameter temp_t TEMP_INIT       = TEMP_INIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_default,
   output logic [7:0] changed_temp,
   output logic       changed_strobe
);

   generate
      if (!(TEMP_MIN <= TEMP_INIT && TEMP_INIT <= TEMP_MAX && TEMP_MAX <= 8'd99 &&
            DEBOUNCE_CYCLES >= 1 && REPEAT_DELAY >= 1 && REPEAT_PERIOD >= 1))
      begin : g_param_check
         $error("setpoint_entry: illegal parameter set");
      end
   endgenerate

   logic up_lvl, dn_lvl, def_lvl;
   logic up_q, dn_q, def_q;
   logic up_press, dn_press, def_press;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk(clk), .rst_n(rst_n), .raw(btn_up), .level(up_lvl));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk(clk), .rst_n(rst_n), .raw(btn_down), .level(dn_lvl));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_default (
      .clk(clk), .rst_n(rst_n), .raw(btn_default), .level(def_lvl));

   assign up_press  = up_lvl  & ~up_q;
   assign dn_press  = dn_lvl  & ~dn_q;
   assign def_press = def_lvl & ~def_q;

   rep_state_t state, state_nxt;
   temp_t      temp, temp_nxt;

`ifdef SETPOINT_AUTOREPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW       = $clog2(HOLD_MAX + 1);
   logic [HW-1:0] hold_cnt, cnt_nxt;
`endif

   always_comb begin
      state_nxt = state;
      temp_nxt  = temp;
`ifdef SETPOINT_AUTOREPEAT_EN
      cnt_nxt   = hold_cnt;
`endif
      if (def_press) begin
         temp_nxt  = TEMP_INIT;
         state_nxt = IDLE;
      end else if (def_lvl || (up_lvl && dn_lvl)) begin
         // Default held or both directions held: no stepping at all.
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (up_press || dn_press) begin
                  temp_nxt  = step_temp(temp, up_press, TEMP_MIN, TEMP_MAX);
`ifdef SETPOINT_AUTOREPEAT_EN
                  state_nxt = HOLD_DELAY;
                  cnt_nxt   = '0;
`endif
               end
            end
`ifdef SETPOINT_AUTOREPEAT_EN
            HOLD_DELAY: begin
               if (!(up_lvl || dn_lvl)) begin
                  state_nxt = IDLE;
               end else if (hold_cnt == HW'(REPEAT_DELAY - 1)) begin
                  temp_nxt  = step_temp(temp, up_lvl, TEMP_MIN, TEMP_MAX);
                  state_nxt = REPEAT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = hold_cnt + HW'(1);
               end
            end
            REPEAT: begin
               if (!(up_lvl || dn_lvl)) begin
                  state_nxt = IDLE;
               end else if (hold_cnt == HW'(REPEAT_PERIOD - 1)) begin
                  temp_nxt = step_temp(temp, up_lvl, TEMP_MIN, TEMP_MAX);
                  cnt_nxt  = '0;
               end else begin
                  cnt_nxt = hold_cnt + HW'(1);
               end
            end
`endif
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         temp           <= TEMP_INIT;
         changed_strobe <= 1'b0;
         up_q           <= 1'b0;
         dn_q           <= 1'b0;
         def_q          <= 1'b0;
`ifdef SETPOINT_AUTOREPEAT_EN
         hold_cnt       <= '0;
`endif
      end else begin
         state          <= state_nxt;
         temp           <= temp_nxt;
         changed_strobe <= (temp_nxt != temp);
         up_q           <= up_lvl;
         dn_q           <= dn_lvl;
         def_q          <= def_lvl;
`ifdef SETPOINT_AUTOREPEAT_EN
         hold_cnt       <= cnt_nxt;
`endif
      end
   end

   assign changed_temp = temp;

endmodule

`default_nettype wire

// File: tb/tb_setpoint_entry.sv
// ============================================================================
// tb_setpoint_entry : table-driven and sequence checks with a strobe scoreboard
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_setpoint_entry;

   localparam int DEB = 4;
   localparam int RD  = 8;
   localparam int RP  = 4;
   localparam int TMIN = 50, TMAX = 90, TINIT = 72;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_default = 1'b0;
   logic [7:0] changed_temp;
   logic       changed_strobe;

   setpoint_entry #(
      .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .TEMP_MIN(8'd50), .TEMP_MAX(8'd90), .TEMP_INIT(8'd72)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
      .btn_default(btn_default), .changed_temp(changed_temp),
      .changed_strobe(changed_strobe)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int first_strobe_cyc = -1;
   int strobe_cnt = 0;
   int press_cyc  = 0;
   int model      = TINIT;
   logic [7:0] expq[$];
   logic [7:0] mon_exp;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every strobe must match the next expected setpoint value.
   always @(negedge clk) begin
      if (changed_strobe) begin
         strobe_cnt = strobe_cnt + 1;
         if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
         checks = checks + 1;
         if (expq.size() == 0) begin
            fails = fails + 1;
            $display("FAIL unexpected_strobe: changed_temp=%0d, no change expected", changed_temp);
         end else begin
            mon_exp = expq.pop_front();
            if (changed_temp !== mon_exp) begin
               fails = fails + 1;
               $display("FAIL strobe_value: changed_temp=%0d, expected %0d", changed_temp, mon_exp);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step(input logic up);
      int old;
      old = model;
      if (up) begin
         if (model < TMAX) model = model + 1;
      end else begin
         if (model > TMIN) model = model - 1;
      end
      if (model != old) expq.push_back(8'(model));
   endtask

   // Pushes the expected values, holds the buttons h cycles, waits for release.
   task automatic press(input logic u, input logic d, input logic f, input int h);
      int n;
      if (f) begin
         if (model != TINIT) begin
            model = TINIT;
            expq.push_back(8'(model));
         end
      end else if (!(u && d)) begin
         n = 1;
`ifdef SETPOINT_AUTOREPEAT_EN
         if (h >= RD + 1) n = n + 1 + (h - (RD + 1)) / RP;
`endif
         repeat (n) model_step(u);
      end
      @(posedge clk); #1;
      press_cyc = cyc;
      btn_up = u; btn_down = d; btn_default = f;
      repeat (h) @(posedge clk);
      #1;
      btn_up = 1'b0; btn_down = 1'b0; btn_default = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("pending_strobes", expq.size(), 0);
      expq.delete();
   endtask

   typedef struct {
      logic u, d, f;
      int   h;
      int   exp_temp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int s0, guard;
      vecs[0] = '{1'b0, 1'b0, 1'b1, 6,  72};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 6,  73};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 6,  72};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 8,  71};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 12, 71};
`ifdef SETPOINT_AUTOREPEAT_EN
      vecs[5] = '{1'b1, 1'b0, 1'b0, 40, 80};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 6,  72};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 20, 68};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 9,  70};
`else
      vecs[5] = '{1'b1, 1'b0, 1'b0, 40, 72};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 6,  72};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 20, 71};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 9,  72};
`endif

      repeat (3) @(posedge clk);
      #1;
      check("reset_temp", changed_temp, TINIT);
      check("reset_strobe", changed_strobe, 0);
      rst_n = 1'b1;

      // Clean 20-cycle up pulse; first strobe 7 cycles after the raw edge.
      first_strobe_cyc = -1;
      press(1'b1, 1'b0, 1'b0, 20);
      check("first_step_latency", first_strobe_cyc - press_cyc, 7);
      check("pulse_temp", changed_temp, model);

      // Bouncing input never settles long enough to be accepted.
      s0 = strobe_cnt;
      for (int i = 0; i < 5; i++) begin
         btn_up = 1'b1; repeat (2) @(posedge clk); #1;
         btn_up = 1'b0; repeat (2) @(posedge clk); #1;
      end
      repeat (12) @(posedge clk);
      #1;
      check("bounce_temp", changed_temp, model);
      check("bounce_strobes", strobe_cnt - s0, 0);

      for (int i = 0; i < 9; i++) begin
         press(vecs[i].u, vecs[i].d, vecs[i].f, vecs[i].h);
         check($sformatf("vec%0d_temp", i), changed_temp, vecs[i].exp_temp);
      end

      // Upper limit: step to 89, then a long hold saturates at 90.
      guard = 0;
      while (model < 89 && guard < 100) begin press(1'b1, 1'b0, 1'b0, 6); guard++; end
      check("reach_89", changed_temp, 89);
      press(1'b1, 1'b0, 1'b0, 30);
      check("upper_clamp", changed_temp, 90);
      s0 = strobe_cnt;
      press(1'b1, 1'b0, 1'b0, 6);
      check("upper_hold_strobes", strobe_cnt - s0, 0);

      // Lower limit.
      guard = 0;
      while (model > TMIN && guard < 100) begin press(1'b0, 1'b1, 1'b0, 6); guard++; end
      s0 = strobe_cnt;
      press(1'b0, 1'b1, 1'b0, 6);
      check("lower_clamp", changed_temp, 50);
      check("lower_hold_strobes", strobe_cnt - s0, 0);

      // Down pressed while up is held: only the up step counts.
      model_step(1'b1);
      @(posedge clk); #1;
      btn_up = 1'b1;
      repeat (6) @(posedge clk); #1;
      btn_down = 1'b1;
      repeat (14) @(posedge clk); #1;
      btn_up = 1'b0; btn_down = 1'b0;
      repeat (12) @(posedge clk); #1;
      check("conflict_temp", changed_temp, 51);
      check("conflict_pending", expq.size(), 0);
      expq.delete();

      // Default from 80.
      guard = 0;
      while (model < 80 && guard < 100) begin press(1'b1, 1'b0, 1'b0, 6); guard++; end
      s0 = strobe_cnt;
      press(1'b0, 1'b0, 1'b1, 6);
      check("default_temp", changed_temp, 72);
      check("default_strobes", strobe_cnt - s0, 1);

      // Asynchronous reset in the middle of a hold at 85.
      guard = 0;
      while (model < 85 && guard < 100) begin press(1'b1, 1'b0, 1'b0, 6); guard++; end
      model_step(1'b1);
`ifdef SETPOINT_AUTOREPEAT_EN
      model_step(1'b1);
`endif
      @(posedge clk); #1;
      btn_up = 1'b1;
      repeat (17) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_temp", changed_temp, 72);
      check("async_reset_strobe", changed_strobe, 0);
      check("pre_reset_pending", expq.size(), 0);
      expq.delete();
      model = TINIT;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_step(1'b1);
      repeat (8) @(posedge clk);
      #1;
      btn_up = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("post_reset_step", changed_temp, 73);
      check("post_reset_pending", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
